// File: rtl/timer_pkg.sv
// Shared types and digit moduli for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int SEC_ONES_MOD = 10;
  localparam int SEC_TENS_MOD = 6;
  localparam int MIN_ONES_MOD = 10;
  localparam int MIN_TENS_MOD = 10;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: clamps on load, wraps to MOD_VALUE-1 on borrow.
module bcd_down_digit #(
  parameter int MOD_VALUE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic       borrow_out,
  output logic [3:0] digit
);

  localparam logic [3:0] MAX_DIGIT = 4'(MOD_VALUE - 1);

  logic [3:0] digit_q, digit_d;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value);
    return (value > MAX_DIGIT) ? MAX_DIGIT : value;
  endfunction

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = clamp_digit(load_digit);
    end else if (borrow_in) begin
      digit_d = (digit_q == 4'd0) ? MAX_DIGIT : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign borrow_out = borrow_in && (digit_q == 4'd0);
  assign digit      = digit_q;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: control FSM, one-second prescaler and a four-digit
// borrow chain; all outputs come straight from flops.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done
);

  localparam int             PW        = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_CYCLES - 1);

  timer_state_t  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          done_q, done_d;
  logic          tick;

  logic [3:0]    digit_val [4];
  logic [4:0]    borrow;
  logic          borrow_unused;

  // Chain order: sec_ones, sec_tens, min_ones, min_tens.
  assign borrow[0] = tick;

  bcd_down_digit #(.MOD_VALUE(SEC_ONES_MOD)) u_sec_ones (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_value[3:0]),
    .borrow_in(borrow[0]), .borrow_out(borrow[1]), .digit(digit_val[0])
  );

  bcd_down_digit #(.MOD_VALUE(SEC_TENS_MOD)) u_sec_tens (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_value[7:4]),
    .borrow_in(borrow[1]), .borrow_out(borrow[2]), .digit(digit_val[1])
  );

  bcd_down_digit #(.MOD_VALUE(MIN_ONES_MOD)) u_min_ones (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_value[11:8]),
    .borrow_in(borrow[2]), .borrow_out(borrow[3]), .digit(digit_val[2])
  );

  bcd_down_digit #(.MOD_VALUE(MIN_TENS_MOD)) u_min_tens (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_value[15:12]),
    .borrow_in(borrow[3]), .borrow_out(borrow[4]), .digit(digit_val[3])
  );

  // Ticks stop at 00:01 -> 00:00, so the chain never borrows out of min_tens.
  assign borrow_unused = borrow[4];
  assign digits        = {digit_val[3], digit_val[2], digit_val[1], digit_val[0]};

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick    = 1'b0;
    if (load) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !pause && (digits != 16'h0000)) state_d = RUNNING;
        end
        RUNNING: begin
          // A pause edge freezes the prescaler so resume picks up mid-second.
          if (pause) begin
            state_d = PAUSED;
          end else if (presc_q == PRESC_MAX) begin
            tick    = 1'b1;
            presc_d = '0;
            if (digits == 16'h0001) state_d = EXPIRED;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (start && !pause) state_d = RUNNING;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUNNING);
    expired_d = (state_d == EXPIRED);
    done_d    = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-based reference model queues the
// expected outputs for every clock edge; a monitor pops and compares after each edge.
module tb_countdown_timer;

  localparam int TC = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;
  localparam int M_EXP  = 3;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        done;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining time as plain seconds.
  int   m_total = 0;
  int   m_state = M_IDLE;
  int   m_presc = 0;
  bit   m_done  = 1'b0;

  countdown_timer #(.TICK_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .digits(digits), .running(running),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic int load_secs(input logic [15:0] v);
    int mt, mo, st, so;
    mt = clamp(int'(v[15:12]), 9);
    mo = clamp(int'(v[11:8]), 9);
    st = clamp(int'(v[7:4]), 5);
    so = clamp(int'(v[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model(input bit rst, input bit ld, input logic [15:0] lv,
                       input bit st, input bit ps);
    m_done = 1'b0;
    if (rst) begin
      m_total = 0; m_state = M_IDLE; m_presc = 0;
    end else if (ld) begin
      m_total = load_secs(lv); m_state = M_IDLE; m_presc = 0;
    end else begin
      case (m_state)
        M_IDLE: if (st && !ps && m_total != 0) m_state = M_RUN;
        M_RUN: begin
          if (ps) begin
            m_state = M_PAUS;
          end else if (m_presc == TC - 1) begin
            m_presc = 0;
            m_total = m_total - 1;
            if (m_total == 0) begin
              m_state = M_EXP;
              m_done  = 1'b1;
            end
          end else begin
            m_presc = m_presc + 1;
          end
        end
        M_PAUS: if (st && !ps) m_state = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [15:0] lv,
                      input bit st, input bit ps);
    exp_t e;
    @(negedge clk);
    reset = rst; load = ld; load_value = lv; start = st; pause = ps;
    model(rst, ld, lv, st, ps);
    e.digits  = to_bcd(m_total);
    e.running = (m_state == M_RUN);
    e.expired = (m_state == M_EXP);
    e.done    = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] v);
    step(1'b0, 1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic do_pause();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared 1 time unit after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("digits",  digits,          e.digits);
        chk("running", {15'd0, running}, {15'd0, e.running});
        chk("expired", {15'd0, expired}, {15'd0, e.expired});
        chk("done",    {15'd0, done},    {15'd0, e.done});
      end
    end
  end

  initial begin : stimulus
    logic [15:0] lv;
    bit          rst, ld, st, ps;

    // Reset for two cycles, then idle with no inputs.
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle(4);

    // Countdown through mod-6 borrow to expiry, plus a few cycles after.
    do_load(16'h0102);
    do_start();
    idle(250);

    // Pause with prescaler at 2, hold, resume.
    do_load(16'h0005);
    do_start();
    idle(2);
    do_pause();
    idle(10);
    do_start();
    idle(6);

    // Clamping and borrow across minutes.
    do_load(16'h9999);
    do_start();
    idle(5);
    do_load(16'h1000);
    do_start();
    idle(5);

    // Ignored and overriding inputs.
    do_load(16'h0000);
    do_start();
    idle(2);
    do_load(16'h0001);
    do_start();
    idle(5);
    do_start();
    do_pause();
    idle(2);
    do_load(16'h0003);
    idle(2);
    step(1'b0, 1'b1, 16'h0042, 1'b1, 1'b0);
    idle(3);

    // Reset mid-run at 00:02; a following start must be ignored.
    do_load(16'h0003);
    do_start();
    idle(6);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_start();
    idle(6);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      ld  = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 3) == 0) lv = 16'($urandom);
      else                           lv = 16'($urandom_range(0, 25));
      st  = ($urandom_range(0, 7) == 0);
      ps  = !st && ($urandom_range(0, 15) == 0);
      step(rst, ld, lv, st, ps);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    if (checks == 0) begin
      errors++;
      $display("FAIL no_checks: got 0 comparisons, expected more than 0");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
